// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: loader FSM encoding and the default sizing used by the loader and its FIFO.
package rom_loader_pkg;

   localparam int DEF_ADDR_W     = 22;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH
   } state_t;

endpackage

// File: rtl/rom_loader_word_fifo.sv
// word_fifo: 16-bit synchronous FIFO with full/empty flags; a pop frees a slot for a push in the same cycle.
module word_fifo
   import rom_loader_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] head,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [15:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
         else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs MCU ROM bytes little-endian into 16-bit words and writes them to memory via req/ack.
// Build macro ROM_LOADER_CSUM_EN adds the csum output (16-bit sum of accepted bytes).
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rom_loading,
   input  logic [7:0]        rom_do,
   input  logic              rom_do_valid,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              busy,
   output logic              done,
   output logic [23:0]       byte_count,
   output logic              overflow
`ifdef ROM_LOADER_CSUM_EN
   ,
   output logic [15:0]       csum
`endif
);

   state_t      state;
   state_t      state_nxt;
   logic        loading_now;
   logic        loading_q;
   logic        start;
   logic        stop;
   logic        in_load;
   logic        accept;
   logic        clear;
   logic        phase;
   logic [7:0]  pack_lo;
   logic        push;
   logic        pop;
   logic [15:0] push_data;
   logic        fifo_full;
   logic        fifo_empty;
   logic [15:0] fifo_head;

   assign loading_now = (rom_loading != 8'h00);
   assign start       = loading_now && !loading_q;
   assign stop        = !loading_now && loading_q;
   assign in_load     = (state == ST_LOAD);
   assign accept      = in_load && rom_do_valid;
   assign clear       = (state == ST_IDLE) && start;
   assign pop         = mem_req && mem_ack;

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            busy = 1'b1;
            if (stop) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            busy = 1'b1;
            if (fifo_empty && !mem_req) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The stop cycle may carry a byte; it and any pending low byte leave as a single (possibly padded) word.
   always_comb begin
      push      = 1'b0;
      push_data = {8'h00, rom_do};
      if (in_load) begin
         if (rom_do_valid && phase) begin
            push      = 1'b1;
            push_data = {rom_do, pack_lo};
         end else if (stop && rom_do_valid) begin
            push      = 1'b1;
            push_data = {8'h00, rom_do};
         end else if (stop && phase) begin
            push      = 1'b1;
            push_data = {8'h00, pack_lo};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         loading_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         loading_q <= loading_now;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_count <= '0;
         phase      <= 1'b0;
         pack_lo    <= '0;
         overflow   <= 1'b0;
      end else if (clear) begin
         byte_count <= '0;
         phase      <= 1'b0;
         pack_lo    <= '0;
         overflow   <= 1'b0;
      end else begin
         if (accept) begin
            if (byte_count != 24'hFF_FFFF) byte_count <= byte_count + 24'd1;
            if (!phase) pack_lo <= rom_do;
         end
         if (in_load && stop) phase <= 1'b0;
         else if (accept)     phase <= !phase;
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   // mem_din is captured from the FIFO head when the request is raised, so it holds until the ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req  <= 1'b0;
         mem_din  <= '0;
         mem_addr <= '0;
      end else begin
         if (clear)    mem_addr <= '0;
         else if (pop) mem_addr <= mem_addr + ADDR_W'(1);
         if (pop) begin
            mem_req <= 1'b0;
         end else if (!mem_req && !fifo_empty) begin
            mem_req <= 1'b1;
            mem_din <= fifo_head;
         end
      end
   end

   word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef ROM_LOADER_CSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       csum <= '0;
      else if (clear)  csum <= '0;
      else if (accept) csum <= csum + {8'h00, rom_do};
   end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench; a memory responder logs writes and a byte-list model predicts them.
`timescale 1ns/1ps
module tb_rom_loader;

   localparam int ADDR_W = 22;
   localparam int DEPTH  = 8;

   typedef logic [7:0]  byte_q_t [$];
   typedef logic [15:0] word_q_t [$];

   logic              clk;
   logic              reset;
   logic [7:0]        rom_loading;
   logic [7:0]        rom_do;
   logic              rom_do_valid;
   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic              busy;
   logic              done;
   logic [23:0]       byte_count;
   logic              overflow;
`ifdef ROM_LOADER_CSUM_EN
   logic [15:0]       csum;
`endif

   logic              resp_ack;
   logic              stray_ack;
   bit                ack_en;
   int                n_checks;
   int                n_fail;
   logic [ADDR_W-1:0] wr_addr [$];
   logic [15:0]       wr_data [$];

   assign mem_ack = resp_ack | stray_ack;

   rom_loader #(
      .ADDR_W    (ADDR_W),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rom_loading (rom_loading),
      .rom_do      (rom_do),
      .rom_do_valid(rom_do_valid),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .busy        (busy),
      .done        (done),
      .byte_count  (byte_count),
      .overflow    (overflow)
`ifdef ROM_LOADER_CSUM_EN
      ,
      .csum        (csum)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory controller model: acks one cycle after a request is seen and logs every completed write.
   initial begin : responder
      int                age;
      logic [ADDR_W-1:0] h_addr;
      logic [15:0]       h_din;
      age      = 0;
      resp_ack = 1'b0;
      h_addr   = '0;
      h_din    = '0;
      forever begin
         @(posedge clk);
         #1;
         resp_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (age > 0) begin
               n_checks++;
               if (mem_addr !== h_addr || mem_din !== h_din) begin
                  n_fail++;
                  $display("FAIL req_stable: addr/din %h/%h, expected held %h/%h", mem_addr, mem_din, h_addr, h_din);
               end
            end
            h_addr = mem_addr;
            h_din  = mem_din;
            if (ack_en && age >= 1) begin
               resp_ack = 1'b1;
               wr_addr.push_back(mem_addr);
               wr_data.push_back(mem_din);
               age = 0;
            end else begin
               age++;
            end
         end else begin
            age = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic word_q_t pack_words(input byte_q_t b);
      word_q_t w;
      for (int i = 0; i < b.size(); i += 2)
         w.push_back({(i + 1 < b.size()) ? b[i+1] : 8'h00, b[i]});
      return w;
   endfunction

   task automatic check_idle_outputs(input string name);
      n_checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
          byte_count !== 24'd0 || mem_addr !== '0 || mem_din !== 16'h0000) begin
         n_fail++;
         $display("FAIL %s: req=%b busy=%b done=%b ovf=%b cnt=%h addr=%h din=%h, expected all zero",
                  name, mem_req, busy, done, overflow, byte_count, mem_addr, mem_din);
      end
`ifdef ROM_LOADER_CSUM_EN
      n_checks++;
      if (csum !== 16'h0000) begin
         n_fail++;
         $display("FAIL %s csum: got %h, expected 0000", name, csum);
      end
`endif
   endtask

   task automatic start_load(input string name);
      wr_addr.delete();
      wr_data.delete();
      rom_loading = 8'($urandom_range(1, 255));
      repeat (3) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_in_load: got %b, expected 1", name, busy);
      end
   endtask

   task automatic send_bytes(input byte_q_t b, input bit stop_last);
      for (int i = 0; i < b.size(); i++) begin
         rom_do       = b[i];
         rom_do_valid = 1'b1;
         if (stop_last && i == b.size() - 1) rom_loading = 8'h00;
         tick();
         rom_do_valid = 1'b0;
         rom_do       = 8'($urandom);
         if (i != b.size() - 1) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   // Waits for done; a stray byte two cycles after stop must be ignored (FLUSH or IDLE).
   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (c == 1) begin
            rom_do       = 8'($urandom);
            rom_do_valid = 1'b1;
         end
         if (c == 2) rom_do_valid = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      rom_do_valid = 1'b0;
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s done_seen: got 0, expected a done pulse within 2000 cycles", name);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, expected 0/0", name, done, busy);
      end
   endtask

   task automatic compare_writes(input word_q_t exp_w, input string name);
      int n;
      n_checks++;
      if (wr_data.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d, expected %0d", name, wr_data.size(), exp_w.size());
      end
      n = (wr_data.size() < exp_w.size()) ? wr_data.size() : exp_w.size();
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got addr %h data %h, expected addr %h data %h",
                     name, i, wr_addr[i], wr_data[i], ADDR_W'(i), exp_w[i]);
         end
      end
   endtask

   task automatic end_and_check(input byte_q_t b, input bit stop_last, input string name);
      if (!stop_last) begin
         repeat ($urandom_range(0, 2)) tick();
         rom_loading = 8'h00;
         tick();
      end
      wait_done(name);
      n_checks++;
      if (byte_count !== 24'(b.size())) begin
         n_fail++;
         $display("FAIL %s byte_count: got %0d, expected %0d", name, byte_count, b.size());
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL %s overflow: got %b, expected 0", name, overflow);
      end
      compare_writes(pack_words(b), name);
`ifdef ROM_LOADER_CSUM_EN
      begin
         int sum;
         sum = 0;
         foreach (b[i]) sum += int'(b[i]);
         n_checks++;
         if (csum !== 16'(sum)) begin
            n_fail++;
            $display("FAIL %s csum: got %h, expected %h", name, csum, 16'(sum));
         end
      end
`endif
   endtask

   task automatic run_load(input byte_q_t b, input bit stop_last, input string name);
      start_load(name);
      send_bytes(b, stop_last);
      end_and_check(b, stop_last, name);
   endtask

   task automatic test_reset;
      repeat (3) tick();
      check_idle_outputs("reset_held");
      reset = 1'b0;
      repeat (2) tick();
      check_idle_outputs("reset_released");
   endtask

   task automatic test_even_load;
      byte_q_t b;
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_load(b, 1'b0, "even_load");
   endtask

   task automatic test_odd_pad;
      byte_q_t b;
      b = '{8'hAA, 8'hBB, 8'hCC};
      run_load(b, 1'b0, "odd_pad");
   endtask

   task automatic test_stop_byte;
      byte_q_t b;
      b = '{8'h01, 8'h02, 8'h03};
      run_load(b, 1'b1, "stop_byte_odd");
      b = '{8'h10, 8'h20};
      run_load(b, 1'b1, "stop_byte_even");
   endtask

   task automatic test_latency;
      byte_q_t b;
      b = '{8'h12, 8'h34};
      start_load("latency");
      rom_do = 8'h12; rom_do_valid = 1'b1;
      tick();
      rom_do = 8'h34;
      tick();
      rom_do_valid = 1'b0;
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL latency req_n1: got %b, expected 0", mem_req);
      end
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || mem_din !== 16'h3412) begin
         n_fail++;
         $display("FAIL latency req_n2: req=%b din=%h, expected 1/3412", mem_req, mem_din);
      end
      end_and_check(b, 1'b0, "latency");
   endtask

   task automatic test_stray_ack;
      byte_q_t b;
      b = '{8'h5A, 8'hA5, 8'h3C};
      start_load("stray_ack");
      repeat (2) begin
         stray_ack = 1'b1;
         tick();
      end
      stray_ack = 1'b0;
      send_bytes(b, 1'b0);
      end_and_check(b, 1'b0, "stray_ack");
   endtask

   task automatic test_overflow;
      byte_q_t b;
      word_q_t exp_w;
      for (int i = 0; i < 2 * (DEPTH + 1); i++) b.push_back(8'($urandom));
      exp_w = pack_words(b);
      while (exp_w.size() > DEPTH) void'(exp_w.pop_back());
      ack_en = 1'b0;
      start_load("overflow");
      send_bytes(b, 1'b0);
      repeat (2) tick();
      n_checks++;
      if (overflow !== 1'b1 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow flag: ovf=%b req=%b, expected 1/1", overflow, mem_req);
      end
      rom_loading = 8'h00;
      tick();
      ack_en = 1'b1;
      wait_done("overflow");
      n_checks++;
      if (overflow !== 1'b1 || byte_count !== 24'(b.size())) begin
         n_fail++;
         $display("FAIL overflow sticky: ovf=%b cnt=%0d, expected 1/%0d", overflow, byte_count, b.size());
      end
      compare_writes(exp_w, "overflow");
   endtask

   task automatic test_random;
      byte_q_t b;
      for (int it = 0; it < 10; it++) begin
         b.delete();
         for (int i = 0; i < int'($urandom_range(1, 12)); i++) b.push_back(8'($urandom));
         run_load(b, 1'($urandom_range(0, 1)), $sformatf("random%0d", it));
      end
   endtask

   task automatic test_reset_midload;
      byte_q_t b;
      bit      seen;
      ack_en = 1'b0;
      start_load("reset_mid");
      rom_do = 8'h77; rom_do_valid = 1'b1;
      tick();
      rom_do = 8'h88;
      tick();
      rom_do_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (mem_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL reset_mid req_seen: got 0, expected mem_req within 20 cycles");
      end
      #3;
      reset       = 1'b1;
      rom_loading = 8'h00;
      #1;
      check_idle_outputs("reset_mid_async");
      repeat (2) tick();
      reset  = 1'b0;
      ack_en = 1'b1;
      tick();
      b = '{8'hC3, 8'h5A};
      run_load(b, 1'b0, "after_reset");
   endtask

`ifdef ROM_LOADER_CSUM_EN
   task automatic test_csum;
      byte_q_t b;
      b = '{8'hFF, 8'hFF, 8'h02};
      run_load(b, 1'b0, "csum");
      n_checks++;
      if (csum !== 16'h0200) begin
         n_fail++;
         $display("FAIL csum_vector: got %h, expected 0200", csum);
      end
   endtask
`endif

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      rom_loading  = 8'h00;
      rom_do       = 8'h00;
      rom_do_valid = 1'b0;
      stray_ack    = 1'b0;
      ack_en       = 1'b1;
      test_reset();
      test_even_load();
      test_odd_pad();
      test_stop_byte();
      test_latency();
      test_stray_ack();
      test_overflow();
      test_random();
      test_reset_midload();
`ifdef ROM_LOADER_CSUM_EN
      test_csum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
